// File: rtl/mux_n_to_1_reg_if.sv
// Handshake bus for mux_n_to_1_reg: input side (data/select/valid/ready),
// output side (resultado/valid/ready) and select-error reporting.
interface mux_n_to_1_reg_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 3,
   parameter int unsigned SEL_W = 2
);
   logic [N*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]   select;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   resultado;
   logic               out_valid;
   logic               out_ready;
   logic               erro_clr;
   logic               sel_erro;
   logic [7:0]         erro_cnt;

   // Producer/consumer view driving the block
   modport master (
      output data_in, select, in_valid, out_ready, erro_clr,
      input  in_ready, resultado, out_valid, sel_erro, erro_cnt
   );

   // Block view
   modport slave (
      input  data_in, select, in_valid, out_ready, erro_clr,
      output in_ready, resultado, out_valid, sel_erro, erro_cnt
   );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// Registered N-to-1 selector feeding a 2-entry FIFO, with out-of-range select
// detection (sticky flag plus saturating counter).
// Optional feature macro: MUX_HOLD_LAST_EN -- an out-of-range select enqueues
// the last successfully enqueued value instead of being dropped.
module mux_n_to_1_reg #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 3,
   parameter int unsigned SEL_W = 2
) (
   input logic            clock,
   input logic            reset_n,
   mux_n_to_1_reg_if.slave bus
);

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             sel_erro_q, sel_erro_d;
   logic [7:0]       erro_cnt_q, erro_cnt_d;

   logic             push, pop, enq, sel_ok;
   logic [WIDTH-1:0] sel_data, enq_data;

   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.resultado = head_q;
   assign bus.sel_erro  = sel_erro_q;
   assign bus.erro_cnt  = erro_cnt_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // Channel select; sel_ok stays low for codes >= N
   always_comb begin
      sel_data = '0;
      sel_ok   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (bus.select == SEL_W'(k)) begin
            sel_data = bus.data_in[k*WIDTH +: WIDTH];
            sel_ok   = 1'b1;
         end
      end
   end

`ifdef MUX_HOLD_LAST_EN
   logic [WIDTH-1:0] last_q, last_d;

   assign enq      = push;
   assign enq_data = sel_ok ? sel_data : last_q;

   // Remember the last in-range value for replay on bad selects
   always_comb begin
      last_d = last_q;
      if (push && sel_ok) last_d = sel_data;
   end

   // Last-value register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) last_q <= '0;
      else          last_q <= last_d;
   end
`else
   assign enq      = push && sel_ok;
   assign enq_data = sel_data;
`endif

   // FIFO next state: head is always entry 0, tail shifts in on pop
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case ({enq, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = enq_data;
            else                 tail_d = enq_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // Only reachable with count 1, since enq needs in_ready
         2'b11:   head_d = enq_data;
         default: ;
      endcase
   end

   // Error flag/counter next state; a new error beats a coincident clear
   always_comb begin
      sel_erro_d = sel_erro_q;
      erro_cnt_d = erro_cnt_q;
      if (push && !sel_ok) begin
         sel_erro_d = 1'b1;
         if (bus.erro_clr)              erro_cnt_d = 8'd1;
         else if (erro_cnt_q != 8'hFF)  erro_cnt_d = erro_cnt_q + 8'd1;
      end else if (bus.erro_clr) begin
         sel_erro_d = 1'b0;
         erro_cnt_d = 8'd0;
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         sel_erro_q <= 1'b0;
         erro_cnt_q <= 8'd0;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         sel_erro_q <= sel_erro_d;
         erro_cnt_q <= erro_cnt_d;
      end
   end

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Bench for mux_n_to_1_reg: directed vectors on an N=3/WIDTH=16 instance and a
// queue-scoreboarded random run on an N=8/WIDTH=32 instance.
module tb_mux_n_to_1_reg;

   logic clock;
   logic reset_n;

   int n_checks;
   int n_errors;

   mux_n_to_1_reg_if #(.WIDTH(16), .N(3), .SEL_W(2)) a_if ();
   mux_n_to_1_reg_if #(.WIDTH(32), .N(8), .SEL_W(4)) b_if ();

   mux_n_to_1_reg #(.WIDTH(16), .N(3), .SEL_W(2)) u_dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (a_if.slave)
   );

   mux_n_to_1_reg #(.WIDTH(32), .N(8), .SEL_W(4)) u_dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (b_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] sb_q[$];
   logic [31:0] sb_last;
   int          sb_bad;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One random-run cycle on instance B; outputs are observed before the edge
   task automatic rnd_step(input bit gen);
      int          sel;
      logic [31:0] exp;
      if (gen) begin
         for (int k = 0; k < 8; k++) b_if.data_in[k*32 +: 32] = $urandom;
         if ($urandom_range(0, 7) == 0) sel = $urandom_range(8, 15);
         else                           sel = $urandom_range(0, 7);
         b_if.select    = 4'(sel);
         b_if.in_valid  = ($urandom_range(0, 3) != 0);
         b_if.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         sel            = 0;
         b_if.in_valid  = 1'b0;
         b_if.out_ready = 1'b1;
      end
      check_eq("rnd_valid", 32'(b_if.out_valid), 32'(sb_q.size() != 0));
      check_eq("rnd_ready", 32'(b_if.in_ready), 32'(sb_q.size() != 2));
      if (b_if.out_valid && b_if.out_ready && sb_q.size() != 0) begin
         exp = sb_q.pop_front();
         check_eq("rnd_data", b_if.resultado, exp);
      end
      if (b_if.in_valid && b_if.in_ready) begin
         if (sel < 8) begin
            exp     = b_if.data_in[sel*32 +: 32];
            sb_last = exp;
            sb_q.push_back(exp);
         end else begin
            sb_bad++;
`ifdef MUX_HOLD_LAST_EN
            sb_q.push_back(sb_last);
`endif
         end
      end
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      sb_last  = '0;
      sb_bad   = 0;

      reset_n        = 1'b0;
      a_if.data_in   = '0;
      a_if.select    = '0;
      a_if.in_valid  = 1'b0;
      a_if.out_ready = 1'b0;
      a_if.erro_clr  = 1'b0;
      b_if.data_in   = '0;
      b_if.select    = '0;
      b_if.in_valid  = 1'b0;
      b_if.out_ready = 1'b0;
      b_if.erro_clr  = 1'b0;

      #2;
      check_eq("rst_out_valid", 32'(a_if.out_valid), 32'd0);
      check_eq("rst_in_ready",  32'(a_if.in_ready),  32'd1);
      check_eq("rst_resultado", 32'(a_if.resultado), 32'h0);
      check_eq("rst_sel_erro",  32'(a_if.sel_erro),  32'd0);
      check_eq("rst_erro_cnt",  32'(a_if.erro_cnt),  32'd0);
      #10;
      reset_n = 1'b1;
      tick();

      // Stream selects 0,1,2 with out_ready high
      a_if.data_in   = {16'h3333, 16'h2222, 16'h1111};
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.select    = 2'd0;
      tick();
      check_eq("stream0_valid", 32'(a_if.out_valid), 32'd1);
      check_eq("stream0_data",  32'(a_if.resultado), 32'h1111);
      a_if.select = 2'd1;
      tick();
      check_eq("stream1_data",  32'(a_if.resultado), 32'h2222);
      check_eq("stream1_ready", 32'(a_if.in_ready),  32'd1);
      a_if.select = 2'd2;
      tick();
      check_eq("stream2_data",  32'(a_if.resultado), 32'h3333);
      a_if.in_valid = 1'b0;
      tick();
      check_eq("stream_drained", 32'(a_if.out_valid), 32'd0);

      // Fill with out_ready low, then drain
      a_if.out_ready = 1'b0;
      a_if.select    = 2'd0;
      a_if.data_in   = {16'h3333, 16'h2222, 16'hAAAA};
      a_if.in_valid  = 1'b1;
      tick();
      check_eq("fill1_ready", 32'(a_if.in_ready),  32'd1);
      check_eq("fill1_data",  32'(a_if.resultado), 32'hAAAA);
      a_if.data_in = {16'h3333, 16'h2222, 16'hBBBB};
      tick();
      check_eq("fill2_ready", 32'(a_if.in_ready),  32'd0);
      check_eq("fill2_head",  32'(a_if.resultado), 32'hAAAA);
      a_if.in_valid = 1'b0;
      tick();
      check_eq("hold_valid", 32'(a_if.out_valid), 32'd1);
      check_eq("hold_data",  32'(a_if.resultado), 32'hAAAA);
      a_if.out_ready = 1'b1;
      tick();
      check_eq("pop1_data",  32'(a_if.resultado), 32'hBBBB);
      check_eq("pop1_ready", 32'(a_if.in_ready),  32'd1);
      tick();
      check_eq("pop2_empty", 32'(a_if.out_valid), 32'd0);

      // Single out-of-range select
      a_if.select   = 2'd3;
      a_if.in_valid = 1'b1;
      tick();
      check_eq("bad_sel_erro", 32'(a_if.sel_erro), 32'd1);
      check_eq("bad_erro_cnt", 32'(a_if.erro_cnt), 32'd1);
`ifdef MUX_HOLD_LAST_EN
      check_eq("bad_out_valid", 32'(a_if.out_valid), 32'd1);
      check_eq("bad_replay",    32'(a_if.resultado), 32'hBBBB);
`else
      check_eq("bad_out_valid", 32'(a_if.out_valid), 32'd0);
`endif
      check_eq("bad_in_ready", 32'(a_if.in_ready), 32'd1);

      // Saturation: 300 more bad pushes
      for (int i = 0; i < 300; i++) tick();
      check_eq("sat_erro_cnt", 32'(a_if.erro_cnt), 32'd255);
      check_eq("sat_sel_erro", 32'(a_if.sel_erro), 32'd1);
      a_if.erro_clr = 1'b1;
      tick();
      check_eq("clr_vs_err_cnt",  32'(a_if.erro_cnt), 32'd1);
      check_eq("clr_vs_err_flag", 32'(a_if.sel_erro), 32'd1);
      a_if.in_valid = 1'b0;
      tick();
      check_eq("clr_cnt",  32'(a_if.erro_cnt), 32'd0);
      check_eq("clr_flag", 32'(a_if.sel_erro), 32'd0);
      a_if.erro_clr = 1'b0;
      tick();
      check_eq("clr_drained", 32'(a_if.out_valid), 32'd0);

      // Reset with buffer full, checked before any clock edge
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.select    = 2'd1;
      tick();
      a_if.select = 2'd2;
      tick();
      check_eq("full_ready", 32'(a_if.in_ready), 32'd0);
      a_if.in_valid = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_valid", 32'(a_if.out_valid), 32'd0);
      check_eq("async_rst_ready", 32'(a_if.in_ready),  32'd1);
      check_eq("async_rst_data",  32'(a_if.resultado), 32'h0);
      #1;
      reset_n = 1'b1;
      tick();

      // Bad select right after reset: replay value is 0 when enabled
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.select    = 2'd3;
      tick();
      check_eq("post_rst_err_cnt", 32'(a_if.erro_cnt), 32'd1);
`ifdef MUX_HOLD_LAST_EN
      check_eq("post_rst_replay_valid", 32'(a_if.out_valid), 32'd1);
      check_eq("post_rst_replay_zero",  32'(a_if.resultado), 32'h0);
`else
      check_eq("post_rst_drop", 32'(a_if.out_valid), 32'd0);
`endif
      a_if.select = 2'd2;
      tick();
      check_eq("post_rst_valid", 32'(a_if.out_valid), 32'd1);
      check_eq("post_rst_data",  32'(a_if.resultado), 32'h3333);
      a_if.in_valid = 1'b0;
      tick();

      // Random run on the N=8 instance
      for (int i = 0; i < 4000; i++) rnd_step(1'b1);
      for (int i = 0; i < 4; i++)    rnd_step(1'b0);
      check_eq("rnd_queue_empty", 32'(sb_q.size()), 32'd0);
      check_eq("rnd_erro_cnt", 32'(b_if.erro_cnt), (sb_bad > 255) ? 32'd255 : 32'(sb_bad));
      check_eq("rnd_sel_erro", 32'(b_if.sel_erro), 32'(sb_bad != 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
